// File: rtl/difftest_endpoint_pkg.sv
// Shared encodings for the multi-core difftest endpoint: run status codes, FSM states, good-exit value.
package difftest_endpoint_pkg;

  localparam logic [2:0] ST_RUNNING  = 3'd0;
  localparam logic [2:0] ST_GOODTRAP = 3'd1;
  localparam logic [2:0] ST_EXCEED   = 3'd2;
  localparam logic [2:0] ST_FAIL     = 3'd3;
  localparam logic [2:0] ST_STUCK    = 3'd5;

  localparam logic [63:0] EXIT_GOOD = {64{1'b1}};

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/difftest_uart_fifo.sv
// Per-core UART byte FIFO with drop counting; read data is combinational from the head entry.
// A push while full is dropped (counter saturates) unless the same cycle also pops.
module difftest_uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_push_vld,
  input  logic [7:0]  i_push_dat,
  input  logic        i_pop,
  output logic [7:0]  o_pop_dat,
  output logic        o_full,
  output logic        o_empty,
  output logic [15:0] o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_drop;
  logic          w_push;
  logic          w_pop;

  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_pop      = i_pop && !o_empty;
  assign w_push     = i_push_vld && (!o_full || w_pop);
  assign o_pop_dat  = r_mem[r_rd_ptr];
  assign o_drop_cnt = r_drop;

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (i_push_vld && !w_push && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
    end
  end

endmodule

// File: rtl/difftest_endpoint_mc.sv
// Multi-core run monitor: latches one run status, counts cycles/steps, merges per-core UART FIFOs round-robin.
// Optional per-core stuck detection under DIFFTEST_STUCK_CHECK_EN; output byte is held until uart_out_ready.
module difftest_endpoint_mc
  import difftest_endpoint_pkg::*;
#(
  parameter  int NUM_CORES  = 2,
  parameter  int STEP_WIDTH = 8,
  parameter  int UART_DEPTH = 16,
  localparam int CW         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [63:0]                     max_cycles,
  input  logic [31:0]                     stuck_limit,
  input  logic [NUM_CORES*STEP_WIDTH-1:0] core_step,
  input  logic [NUM_CORES*64-1:0]         core_exit,
  input  logic [NUM_CORES-1:0]            uart_in_valid,
  input  logic [NUM_CORES*8-1:0]          uart_in_ch,
  output logic                            uart_out_valid,
  input  logic                            uart_out_ready,
  output logic [7:0]                      uart_out_ch,
  output logic [CW-1:0]                   uart_out_core,
  output logic [2:0]                      status,
  output logic                            done,
  output logic [CW-1:0]                   fail_core,
  output logic [63:0]                     fail_code,
  output logic [63:0]                     n_cycles,
  output logic [63:0]                     total_steps,
  output logic [NUM_CORES*16-1:0]         uart_drop
);

  state_e               r_state, w_state_nxt;
  logic [2:0]           r_status;
  logic [CW-1:0]        r_fail_core;
  logic [63:0]          r_fail_code;
  logic [63:0]          r_n_cycles;
  logic [63:0]          r_total_steps;
  logic [NUM_CORES-1:0] r_fin;
  logic [NUM_CORES-1:0] w_fin_nxt;
  logic [63:0]          w_step_sum;
  logic                 w_fail_hit;
  logic [CW-1:0]        w_fail_idx;
  logic [63:0]          w_fail_code;
  logic                 w_stuck_hit;
  logic [CW-1:0]        w_stuck_idx;
  logic                 w_exceed;
  logic                 w_evt;
  logic [2:0]           w_evt_status;

  logic [NUM_CORES-1:0] w_empty;
  logic [NUM_CORES-1:0] w_unused_full;
  logic [NUM_CORES-1:0] w_pop;
  logic [7:0]           w_fifo_dat [NUM_CORES];
  logic [15:0]          w_drop [NUM_CORES];
  logic [CW-1:0]        r_last;
  logic                 r_lock;
  logic [CW-1:0]        r_lock_core;
  logic                 w_rr_vld;
  logic [CW-1:0]        w_rr_idx;
  logic [CW-1:0]        w_sel;
  logic                 w_out_vld;
  logic                 w_hs;

  always_comb begin
    w_step_sum  = '0;
    w_fin_nxt   = r_fin;
    w_fail_hit  = 1'b0;
    w_fail_idx  = '0;
    w_fail_code = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_step_sum = w_step_sum + 64'(core_step[i*STEP_WIDTH +: STEP_WIDTH]);
      if (core_exit[i*64 +: 64] == EXIT_GOOD) w_fin_nxt[i] = 1'b1;
      if (!w_fail_hit && (core_exit[i*64 +: 64] != '0) && (core_exit[i*64 +: 64] != EXIT_GOOD)) begin
        w_fail_hit  = 1'b1;
        w_fail_idx  = CW'(i);
        w_fail_code = core_exit[i*64 +: 64];
      end
    end
  end

`ifdef DIFFTEST_STUCK_CHECK_EN
  logic [31:0] r_timer [NUM_CORES];

  // Timers stop once a core has finished, so a cleanly exited core can never trip STUCK.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CORES; i++) r_timer[i] <= '0;
    end else if (r_state == S_RUN) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!w_fin_nxt[i]) begin
          if (core_step[i*STEP_WIDTH +: STEP_WIDTH] != '0) r_timer[i] <= '0;
          else if (r_timer[i] != 32'hFFFF_FFFF)           r_timer[i] <= r_timer[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    w_stuck_hit = 1'b0;
    w_stuck_idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!w_stuck_hit && !w_fin_nxt[i] && (stuck_limit != '0) && (r_timer[i] >= stuck_limit)) begin
        w_stuck_hit = 1'b1;
        w_stuck_idx = CW'(i);
      end
    end
  end
`else
  logic w_unused_stuck;
  assign w_unused_stuck = ^stuck_limit;
  assign w_stuck_hit    = 1'b0;
  assign w_stuck_idx    = '0;
`endif

  assign w_exceed = (max_cycles != '0) && (r_n_cycles >= max_cycles);

  always_comb begin
    w_state_nxt  = r_state;
    w_evt        = 1'b1;
    w_evt_status = ST_RUNNING;
    if (w_fail_hit)        w_evt_status = ST_FAIL;
    else if (w_stuck_hit)  w_evt_status = ST_STUCK;
    else if (w_exceed)     w_evt_status = ST_EXCEED;
    else if (&w_fin_nxt)   w_evt_status = ST_GOODTRAP;
    else                   w_evt        = 1'b0;
    case (r_state)
      S_RUN:   if (w_evt) w_state_nxt = S_DRAIN;
      S_DRAIN: if (&w_empty) w_state_nxt = S_DONE;
      default: w_state_nxt = S_DONE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_RUN;
      r_status      <= ST_RUNNING;
      r_fail_core   <= '0;
      r_fail_code   <= '0;
      r_n_cycles    <= '0;
      r_total_steps <= '0;
      r_fin         <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_RUN) begin
        r_n_cycles    <= r_n_cycles + 64'd1;
        r_total_steps <= r_total_steps + w_step_sum;
        r_fin         <= w_fin_nxt;
        if (w_evt) begin
          r_status <= w_evt_status;
          if (w_fail_hit) begin
            r_fail_core <= w_fail_idx;
            r_fail_code <= w_fail_code;
          end else if (w_stuck_hit) begin
            r_fail_core <= w_stuck_idx;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_fifo
    difftest_uart_fifo #(.DEPTH(UART_DEPTH)) u_fifo (
      .i_clock    (clock),
      .i_reset_n  (reset_n),
      .i_push_vld (uart_in_valid[g] && (r_state == S_RUN)),
      .i_push_dat (uart_in_ch[g*8 +: 8]),
      .i_pop      (w_pop[g]),
      .o_pop_dat  (w_fifo_dat[g]),
      .o_full     (w_unused_full[g]),
      .o_empty    (w_empty[g]),
      .o_drop_cnt (w_drop[g])
    );
    assign w_pop[g]             = w_hs && (w_sel == CW'(g));
    assign uart_drop[g*16 +: 16] = w_drop[g];
  end

  // Search starts one past the last granted core; a pending offer is locked until it handshakes.
  always_comb begin
    w_rr_vld = 1'b0;
    w_rr_idx = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      int idx;
      idx = int'(r_last) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!w_rr_vld && !w_empty[idx]) begin
        w_rr_vld = 1'b1;
        w_rr_idx = CW'(idx);
      end
    end
  end

  assign w_sel     = r_lock ? r_lock_core : w_rr_idx;
  assign w_out_vld = r_lock || w_rr_vld;
  assign w_hs      = w_out_vld && uart_out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last      <= CW'(NUM_CORES - 1);
      r_lock      <= 1'b0;
      r_lock_core <= '0;
    end else if (w_hs) begin
      r_last <= w_sel;
      r_lock <= 1'b0;
    end else if (w_out_vld) begin
      r_lock      <= 1'b1;
      r_lock_core <= w_sel;
    end
  end

  assign uart_out_valid = w_out_vld;
  assign uart_out_ch    = w_out_vld ? w_fifo_dat[w_sel] : 8'h00;
  assign uart_out_core  = w_out_vld ? w_sel : '0;
  assign status         = r_status;
  assign done           = (r_state == S_DONE);
  assign fail_core      = r_fail_core;
  assign fail_code      = r_fail_code;
  assign n_cycles       = r_n_cycles;
  assign total_steps    = r_total_steps;

endmodule

// File: tb/tb_difftest_endpoint_mc.sv
// Directed bench for difftest_endpoint_mc (2 cores): termination events, counters, UART buffering and drain.
module tb_difftest_endpoint_mc;

  logic         clock;
  logic         reset_n;
  logic [63:0]  max_cycles;
  logic [31:0]  stuck_limit;
  logic [15:0]  core_step;
  logic [127:0] core_exit;
  logic [1:0]   uart_in_valid;
  logic [15:0]  uart_in_ch;
  logic         uart_out_valid;
  logic         uart_out_ready;
  logic [7:0]   uart_out_ch;
  logic [0:0]   uart_out_core;
  logic [2:0]   status;
  logic         done;
  logic [0:0]   fail_core;
  logic [63:0]  fail_code;
  logic [63:0]  n_cycles;
  logic [63:0]  total_steps;
  logic [31:0]  uart_drop;

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] ONES;

`ifdef DIFFTEST_STUCK_CHECK_EN
  localparam int STUCK_RUN = 14;
`else
  localparam int STUCK_RUN = 31;
`endif

  difftest_endpoint_mc #(.NUM_CORES(2), .STEP_WIDTH(8), .UART_DEPTH(16)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .max_cycles     (max_cycles),
    .stuck_limit    (stuck_limit),
    .core_step      (core_step),
    .core_exit      (core_exit),
    .uart_in_valid  (uart_in_valid),
    .uart_in_ch     (uart_in_ch),
    .uart_out_valid (uart_out_valid),
    .uart_out_ready (uart_out_ready),
    .uart_out_ch    (uart_out_ch),
    .uart_out_core  (uart_out_core),
    .status         (status),
    .done           (done),
    .fail_core      (fail_core),
    .fail_code      (fail_code),
    .n_cycles       (n_cycles),
    .total_steps    (total_steps),
    .uart_drop      (uart_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    max_cycles     = '0;
    stuck_limit    = '0;
    core_step      = '0;
    core_exit      = '0;
    uart_in_valid  = '0;
    uart_in_ch     = '0;
    uart_out_ready = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [8:0] exp_byte;
    ONES    = '1;
    reset_n = 1'b1;
    #2;

    // Reset values
    do_reset();
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fail_core", 64'(fail_core), 64'd0);
    chk("rst_fail_code", fail_code, 64'd0);
    chk("rst_n_cycles", n_cycles, 64'd0);
    chk("rst_total_steps", total_steps, 64'd0);
    chk("rst_uart_drop", 64'(uart_drop), 64'd0);
    chk("rst_out_valid", 64'(uart_out_valid), 64'd0);
    chk("rst_out_ch", 64'(uart_out_ch), 64'd0);
    chk("rst_out_core", 64'(uart_out_core), 64'd0);

    // Good trap: core0 exits at cycle 10, core1 at cycle 20
    for (int c = 0; c < 21; c++) begin
      core_step = {8'd1, (c < 10) ? 8'd1 : 8'd0};
      core_exit = {(c == 20) ? ONES : 64'd0, (c >= 10) ? ONES : 64'd0};
      cyc();
      if (c == 19) chk("gt_pre_status", 64'(status), 64'd0);
    end
    chk("gt_status", 64'(status), 64'd1);
    chk("gt_n_cycles", n_cycles, 64'd21);
    chk("gt_total_steps", total_steps, 64'd31);
    chk("gt_done_early", 64'(done), 64'd0);
    core_step = '0;
    core_exit = '0;
    cyc();
    chk("gt_done", 64'(done), 64'd1);
    chk("gt_n_frozen", n_cycles, 64'd21);

    // Error exit on core1 beats good exit on core0 in the same cycle
    do_reset();
    for (int c = 0; c < 8; c++) begin
      core_step = (c < 7) ? 16'h0101 : 16'h0000;
      core_exit = (c == 7) ? {64'h5, ONES} : 128'd0;
      cyc();
    end
    chk("fail_status", 64'(status), 64'd3);
    chk("fail_core", 64'(fail_core), 64'd1);
    chk("fail_code", fail_code, 64'h5);
    chk("fail_n_cycles", n_cycles, 64'd8);
    chk("fail_total", total_steps, 64'd14);
    core_exit = '0;
    cyc();
    chk("fail_done", 64'(done), 64'd1);
    chk("fail_status_hold", 64'(status), 64'd3);

    // Cycle limit
    do_reset();
    max_cycles = 64'd100;
    for (int c = 0; c < 101; c++) begin
      cyc();
      if (c == 99) begin
        chk("exc_pre_status", 64'(status), 64'd0);
        chk("exc_pre_n", n_cycles, 64'd100);
      end
    end
    chk("exc_status", 64'(status), 64'd2);
    chk("exc_n_cycles", n_cycles, 64'd101);
    chk("exc_done_early", 64'(done), 64'd0);
    cyc();
    chk("exc_done", 64'(done), 64'd1);
    chk("exc_n_frozen", n_cycles, 64'd101);

    // Core0 stops stepping at cycle 5
    do_reset();
    max_cycles  = 64'd30;
    stuck_limit = 32'd8;
    for (int c = 0; c < STUCK_RUN; c++) begin
      core_step = {8'd1, (c < 5) ? 8'd1 : 8'd0};
      cyc();
      if (c == STUCK_RUN - 2) chk("stk_pre_status", 64'(status), 64'd0);
    end
`ifdef DIFFTEST_STUCK_CHECK_EN
    chk("stk_status", 64'(status), 64'd5);
    chk("stk_fail_core", 64'(fail_core), 64'd0);
    chk("stk_n_cycles", n_cycles, 64'd14);
`else
    chk("stk_status", 64'(status), 64'd2);
    chk("stk_n_cycles", n_cycles, 64'd31);
`endif

    // UART overflow and round-robin drain
    do_reset();
    for (int k = 0; k < 20; k++) begin
      uart_in_valid = 2'b11;
      uart_in_ch    = {8'h80 + 8'(k), 8'(k)};
      cyc();
    end
    uart_in_valid = 2'b00;
    chk("uart_drop", 64'(uart_drop), 64'h0004_0004);
    chk("uart_first", 64'({uart_out_valid, uart_out_core, uart_out_ch}), 64'h200);
    cyc();
    chk("uart_hold", 64'({uart_out_valid, uart_out_core, uart_out_ch}), 64'h200);
    uart_out_ready = 1'b1;
    for (int j = 0; j < 32; j++) begin
      exp_byte = (j % 2 == 1) ? {1'b1, 8'h80 + 8'(j / 2)} : {1'b0, 8'(j / 2)};
      chk("uart_rr", 64'({uart_out_valid, uart_out_core, uart_out_ch}), 64'({1'b1, exp_byte}));
      cyc();
    end
    chk("uart_empty", 64'(uart_out_valid), 64'd0);
    chk("uart_drop_hold", 64'(uart_drop), 64'h0004_0004);

    // Good exit with 3 queued bytes, ready 1-in-3
    do_reset();
    for (int c = 0; c < 3; c++) begin
      uart_in_valid = 2'b01;
      uart_in_ch    = {8'h00, 8'hA0 + 8'(c)};
      cyc();
    end
    uart_in_valid = 2'b00;
    core_exit     = {ONES, ONES};
    cyc();
    core_exit = '0;
    chk("drn_status", 64'(status), 64'd1);
    chk("drn_done0", 64'(done), 64'd0);
    for (int t = 0; t < 9; t++) begin
      uart_out_ready = (t % 3 == 2);
      if (t % 3 == 2)
        chk("drn_byte", 64'({uart_out_valid, uart_out_core, uart_out_ch}), 64'({2'b10, 8'hA0 + 8'(t / 3)}));
      cyc();
    end
    uart_out_ready = 1'b0;
    chk("drn_done_early", 64'(done), 64'd0);
    cyc();
    chk("drn_done", 64'(done), 64'd1);
    chk("drn_status_hold", 64'(status), 64'd1);

    // Asynchronous reset mid-drain
    do_reset();
    for (int c = 0; c < 3; c++) begin
      uart_in_valid = 2'b10;
      uart_in_ch    = {8'h40 + 8'(c), 8'h00};
      cyc();
    end
    uart_in_valid = 2'b00;
    core_exit     = {ONES, ONES};
    cyc();
    core_exit = '0;
    cyc();
    chk("ar_pre_status", 64'(status), 64'd1);
    chk("ar_pre_out", 64'({uart_out_valid, uart_out_core, uart_out_ch}), 64'h340);
    reset_n = 1'b0;
    #1;
    chk("ar_status", 64'(status), 64'd0);
    chk("ar_out_valid", 64'(uart_out_valid), 64'd0);
    chk("ar_out_core", 64'(uart_out_core), 64'd0);
    chk("ar_n_cycles", n_cycles, 64'd0);
    #1;
    reset_n = 1'b1;
    cyc();
    chk("ar_run_valid", 64'(uart_out_valid), 64'd0);
    chk("ar_run_status", 64'(status), 64'd0);
    chk("ar_run_n", n_cycles, 64'd1);
    chk("ar_run_done", 64'(done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
